// File: rtl/packet_buffer_mem.sv
// -----------------------------------------------------------------------------
// packet_buffer_mem
//   Receive packet buffer. Incoming bytes are written into a circular data
//   memory; a good frame commits its length into a small length FIFO, while an
//   errored or overflowing frame is discarded by rolling the write pointer back
//   to the last commit point. Committed packets stream out on a valid/ready
//   interface with SOP/EOP markers, one byte per cycle while the sink is ready.
//
// Parameters
//   pDATA_W     data byte width
//   pADDR_BITS  data memory address bits (depth = 2**pADDR_BITS bytes)
//   pLEN_BITS   length FIFO pointer bits (holds 2**pLEN_BITS packets)
//   pCNT_W      drop counter width
//
// Ports
//   iclk        clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   idv         receive byte valid, one byte per cycle while high
//   irx_d       receive byte
//   ierr        frame error, sampled while idv=1 and on the first idv=0 cycle
//   o_dv        output byte valid
//   o_data      output byte
//   o_sop       first byte of a packet (qualified by o_dv)
//   o_eop       last byte of a packet (qualified by o_dv)
//   i_ready     sink ready; a byte transfers when o_dv & i_ready
//   o_pkt_cnt   committed packets waiting or in transmission
//   o_drop_cnt  dropped frames, saturating
//   o_full      registered: length FIFO full or data memory full
// -----------------------------------------------------------------------------
module packet_buffer_mem #(
  parameter int pDATA_W    = 8,
  parameter int pADDR_BITS = 11,
  parameter int pLEN_BITS  = 4,
  parameter int pCNT_W     = 16
) (
  input  logic                iclk,
  input  logic                i_rst_n,
  input  logic                idv,
  input  logic [pDATA_W-1:0]  irx_d,
  input  logic                ierr,
  output logic                o_dv,
  output logic [pDATA_W-1:0]  o_data,
  output logic                o_sop,
  output logic                o_eop,
  input  logic                i_ready,
  output logic [pLEN_BITS:0]  o_pkt_cnt,
  output logic [pCNT_W-1:0]   o_drop_cnt,
  output logic                o_full
);

  localparam int DEPTH    = 1 << pADDR_BITS;
  localparam int LF_DEPTH = 1 << pLEN_BITS;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [pADDR_BITS:0] ptr_t;
  typedef logic [pLEN_BITS:0]  lptr_t;

  localparam ptr_t  PTR_ONE  = ptr_t'(1);
  localparam ptr_t  PTR_TWO  = ptr_t'(2);
  localparam ptr_t  MEM_FULL = ptr_t'(DEPTH);
  localparam lptr_t LF_ONE   = lptr_t'(1);
  localparam lptr_t LF_FULL  = lptr_t'(LF_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_RX, W_DROP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} r_state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [pDATA_W-1:0] mem [DEPTH];
  ptr_t               lf_mem [LF_DEPTH];
  logic [pDATA_W-1:0] rdata_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  w_state_e           w_state_q, w_state_d;
  ptr_t               wr_ptr_q, wr_ptr_d;
  ptr_t               wr_commit_q, wr_commit_d;
  ptr_t               len_q, len_d;
  logic               err_q, err_d;

  r_state_e           r_state_q, r_state_d;
  ptr_t               rd_ptr_q, rd_ptr_d;
  ptr_t               remain_q, remain_d;
  logic               dv_q, dv_d;
  logic [pDATA_W-1:0] data_q, data_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;

  lptr_t              lf_wr_q, lf_wr_d;
  lptr_t              lf_rd_q, lf_rd_d;
  logic [pLEN_BITS:0] pkt_cnt_q, pkt_cnt_d;
  logic [pCNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               full_q;

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  ptr_t  used;
  lptr_t lf_used;
  logic  mem_full, lf_full, lf_empty;
  ptr_t  lf_head;
  ptr_t  rd_ptr_p1, rd_ptr_p2;

  assign used      = wr_ptr_q - rd_ptr_q;
  assign mem_full  = (used == MEM_FULL);
  assign lf_used   = lf_wr_q - lf_rd_q;
  assign lf_full   = (lf_used == LF_FULL);
  assign lf_empty  = (lf_wr_q == lf_rd_q);
  assign lf_head   = lf_mem[lf_rd_q[pLEN_BITS-1:0]];
  assign rd_ptr_p1 = rd_ptr_q + PTR_ONE;
  assign rd_ptr_p2 = rd_ptr_q + PTR_TWO;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  logic mem_we, lf_push, drop_inc;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    w_state_d   = w_state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    len_d       = len_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    lf_push     = 1'b0;
    drop_inc    = 1'b0;

    unique case (w_state_q)
      W_IDLE: begin
        if (idv) begin
          // A full memory at frame start would overwrite unread bytes.
          if (lf_full || mem_full) begin
            w_state_d = W_DROP;
          end else begin
            mem_we    = 1'b1;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            len_d     = PTR_ONE;
            err_d     = ierr;
            w_state_d = W_RX;
          end
        end
      end
      W_RX: begin
        if (idv) begin
          if (mem_full) begin
            wr_ptr_d  = wr_commit_q;
            w_state_d = W_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            len_d    = len_q + PTR_ONE;
            err_d    = err_q | ierr;
          end
        end else begin
          // End of frame: ierr is still sampled on this first idle cycle.
          if (err_q | ierr) begin
            wr_ptr_d = wr_commit_q;
            drop_inc = 1'b1;
          end else begin
            lf_push     = 1'b1;
            wr_commit_d = wr_ptr_q;
          end
          w_state_d = W_IDLE;
        end
      end
      W_DROP: begin
        if (!idv) begin
          drop_inc  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  logic                  mem_re, lf_pop, xfer, eop_xfer;
  logic [pADDR_BITS-1:0] raddr;

  assign xfer     = dv_q & i_ready;
  assign eop_xfer = xfer & eop_q;

  always_comb begin
    r_state_d = r_state_q;
    rd_ptr_d  = rd_ptr_q;
    remain_d  = remain_q;
    dv_d      = dv_q;
    data_d    = data_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    lf_pop    = 1'b0;
    mem_re    = 1'b0;
    raddr     = rd_ptr_q[pADDR_BITS-1:0];

    unique case (r_state_q)
      R_IDLE: begin
        if (!lf_empty) begin
          lf_pop    = 1'b1;
          remain_d  = lf_head;
          mem_re    = 1'b1;
          r_state_d = R_LOAD;
        end
      end
      R_LOAD: begin
        dv_d   = 1'b1;
        data_d = rdata_q;
        sop_d  = 1'b1;
        eop_d  = (remain_q == PTR_ONE);
        // Prefetch the second byte so the following transfer sees it ready.
        if (remain_q != PTR_ONE) begin
          mem_re = 1'b1;
          raddr  = rd_ptr_p1[pADDR_BITS-1:0];
        end
        r_state_d = R_SEND;
      end
      R_SEND: begin
        if (xfer) begin
          rd_ptr_d = rd_ptr_p1;
          remain_d = remain_q - PTR_ONE;
          if (remain_q == PTR_ONE) begin
            dv_d      = 1'b0;
            sop_d     = 1'b0;
            eop_d     = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            data_d = rdata_q;
            sop_d  = 1'b0;
            eop_d  = (remain_q == PTR_TWO);
            // Only prefetch bytes that belong to this packet; beyond it the
            // memory is owned by the write side.
            if (remain_q > PTR_TWO) begin
              mem_re = 1'b1;
              raddr  = rd_ptr_p2[pADDR_BITS-1:0];
            end
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    lf_wr_d    = lf_push ? lf_wr_q + LF_ONE : lf_wr_q;
    lf_rd_d    = lf_pop  ? lf_rd_q + LF_ONE : lf_rd_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (lf_push && !eop_xfer) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end else if (!lf_push && eop_xfer) begin
      pkt_cnt_d = pkt_cnt_q - 1'b1;
    end
    if (drop_inc && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      w_state_q   <= W_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      r_state_q   <= R_IDLE;
      rd_ptr_q    <= '0;
      remain_q    <= '0;
      dv_q        <= 1'b0;
      data_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      lf_wr_q     <= '0;
      lf_rd_q     <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      full_q      <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      len_q       <= len_d;
      err_q       <= err_d;
      r_state_q   <= r_state_d;
      rd_ptr_q    <= rd_ptr_d;
      remain_q    <= remain_d;
      dv_q        <= dv_d;
      data_q      <= data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      lf_wr_q     <= lf_wr_d;
      lf_rd_q     <= lf_rd_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      full_q      <= lf_full | mem_full;
    end
  end

  // NOTE: the data memory, length FIFO storage and read register have no
  // reset; pointers define which entries are valid, and a reset here would
  // stop the arrays mapping onto RAM.
  always_ff @(posedge iclk) begin
    if (mem_we) begin
      mem[wr_ptr_q[pADDR_BITS-1:0]] <= irx_d;
    end
    if (mem_re) begin
      rdata_q <= mem[raddr];
    end
    if (lf_push) begin
      lf_mem[lf_wr_q[pLEN_BITS-1:0]] <= len_q;
    end
  end

  assign o_dv       = dv_q;
  assign o_data     = data_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_pkt_cnt  = pkt_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
  assign o_full     = full_q;

endmodule
